// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// sipo_pkg : shared types for the LSB-first serial-in/parallel-out deserializer
// Revision : 1.0
// ============================================================================
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

endpackage
`default_nettype wire

// File: rtl/sipo_shift.sv
`default_nettype none
// ============================================================================
// sipo_shift : WIDTH-bit right-shifting capture register, MSB entry
// Revision   : 1.0
// ============================================================================
module sipo_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Clear and shift in the same cycle leaves only the new bit at the MSB.
  always_comb begin
    shreg_d = shreg_q;
    if (clear) begin
      shreg_d = '0;
    end
    if (shift_en) begin
      shreg_d = WIDTH'({sin, shreg_d} >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign shreg_next = shreg_d;

endmodule
`default_nettype wire

// File: rtl/sipo_deser.sv
`default_nettype none
// ============================================================================
// sipo_deser : LSB-first deserializer with registered valid/ready output
// Revision   : 1.0
// ============================================================================
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  sipo_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic             frame_start;
  logic             bit_accept;
  logic             word_done;
  logic [WIDTH-1:0] shreg_next;

  assign frame_start = sin_valid && start;
  assign bit_accept  = sin_valid && (start || (state_q == SHIFT));
  assign word_done   = sin_valid && !start && (state_q == SHIFT) &&
                       (cnt_q == CNT_W'(WIDTH - 1));

  sipo_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .clear      (frame_start),
    .shift_en   (bit_accept),
    .sin        (sin),
    .shreg_next (shreg_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start bit always opens a fresh frame, even mid-frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_start) begin
      state_d = SHIFT;
      cnt_d   = CNT_W'(1);
    end else if (word_done) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bit_accept) begin
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (word_done) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = shreg_next;
        out_valid_d = 1'b1;
      end else begin
        overrun_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == SHIFT);

endmodule
`default_nettype wire
